// File: rtl/capsense_scanner.sv
// capsense_scanner: time-to-charge capacitive touch scanner with per-pad hysteresis
module capsense_scanner #(
  parameter int NumSense = 4,
  parameter int CountWidth = 16,
  parameter int DischargeCycles = 64,
  parameter int Hysteresis = 8,
  localparam int ChW = NumSense > 1 ? $clog2(NumSense) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [CountWidth-1:0] threshold,
  input  logic [NumSense-1:0]   sense_in,
  output logic [NumSense-1:0]   sense_oe,
  output logic [NumSense-1:0]   touched,
  output logic [NumSense-1:0]   timeout,
  input  logic [ChW-1:0]        rd_sel,
  output logic [CountWidth-1:0] rd_count,
  output logic                  scan_done
);
  localparam int DW = $clog2(DischargeCycles + 1);
  localparam logic [ChW-1:0] LastCh = ChW'(NumSense - 1);
  localparam logic [DW-1:0] DLast = DW'(DischargeCycles - 1);
  localparam logic [CountWidth:0] Hyst = (CountWidth + 1)'(Hysteresis);
  typedef enum logic [1:0] {IDLE, DISCHARGE, MEASURE, STORE} state_t;
  state_t state, state_n;
  logic [NumSense-1:0] s1, s2;
  logic [CountWidth-1:0] counter;
  logic [CountWidth-1:0] count [NumSense];
  logic [ChW-1:0] ch;
  logic [DW-1:0] dcnt;
  logic sat, hit, last, set_t, clr_t;
  assign sat = counter == '1;
  assign hit = s2[ch];
  assign last = ch == LastCh;
  // threshold + hysteresis is formed one bit wider so it cannot wrap
  assign set_t = !sat && {1'b0, counter} >= ({1'b0, threshold} + Hyst);
  assign clr_t = sat || counter < threshold;
  assign rd_count = rd_sel <= LastCh ? count[rd_sel] : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = enable ? DISCHARGE : IDLE;
      DISCHARGE: state_n = !enable ? IDLE : dcnt == DLast ? MEASURE : DISCHARGE;
      MEASURE:   state_n = !enable ? IDLE : (hit || sat) ? STORE : MEASURE;
      default:   state_n = enable ? DISCHARGE : IDLE;
    endcase
    scan_done = state == STORE && last;
    sense_oe = state == MEASURE ? ~(NumSense'(1) << ch) : '1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sense_in;
      s2 <= s1;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ch <= '0;
      dcnt <= '0;
      counter <= '0;
      touched <= '0;
      timeout <= '0;
      for (int i = 0; i < NumSense; i++) count[i] <= '0;
    end else begin
      dcnt <= state == DISCHARGE ? dcnt + 1'b1 : '0;
      counter <= state == MEASURE ? ((hit || sat) ? counter : counter + 1'b1) : '0;
      ch <= state_n == IDLE ? '0 : state == STORE ? (last ? '0 : ch + 1'b1) : ch;
      if (state == STORE) begin
        count[ch] <= counter;
        timeout[ch] <= sat;
        touched[ch] <= set_t ? 1'b1 : clr_t ? 1'b0 : touched[ch];
      end
    end
endmodule
